// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles the cache-side request/wait handshakes and the single RAM port
//   that memory_arbiter sits between.
//
//   Signals
//     iREN, iaddr          instruction read request and address
//     iwait, iload         instruction response (iwait low for one cycle)
//     dREN, dWEN           data read / write requests
//     daddr, dstore        data address and write data
//     dwait, dload         data response (dwait low for one cycle)
//     ramREN, ramWEN       RAM read / write strobes
//     ramaddr, ramstore    RAM address and write data
//     ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//     memerr               sticky error flag
//
//   Modports
//     master  the arbiter: consumes requests and RAM status, drives
//             responses, strobes and the error flag
//     slave   the surrounding cache and RAM model
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Arbitrates the cache's instruction-fetch and data requests onto one RAM
//   port. Each access is a multi-cycle transaction: grant in IDLE, strobe
//   the RAM until it reports ACCESS (or ERROR / timeout), then a one-cycle
//   response pulse in RESP. Data requests win over instruction fetches,
//   except that an instruction fetch that was kept waiting behind a data
//   transaction is served next (ifirst). A transaction that sees ERROR or
//   runs TIMEOUT strobe cycles without ACCESS is aborted, reads return
//   ERRWORD, and the sticky memerr flag is raised until reset.
//
//   Ports
//     CLK    clock, all state changes on the rising edge
//     nRST   synchronous active-low reset
//     bus    memory_arbiter_if.master (requests, responses, RAM port, memerr)
//
//   Parameters
//     TIMEOUT  strobe cycles allowed without ACCESS before abort
//     ERRWORD  read data returned by an aborted read
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    IRD,
    DRD,
    DWR,
    RESP
  } state_t;

  state_t           state;
  state_t           gnt;
  logic             own_d;      // response owner: 1 = data side, 0 = instruction side
  logic             ifirst;     // instruction fetch was held off by a data transaction
  logic             memerr_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      store_q;
  logic [31:0]      iload_q;
  logic [31:0]      dload_q;
  logic             iwait_q;
  logic             dwait_q;
  logic             ren_q;
  logic             wen_q;
  logic             ram_ok;
  logic             ram_abort;

  // IDLE returns "no grant"; ifirst overrides the normal data-first order,
  // and a simultaneous read+write request is treated as a write.
  function automatic state_t arbitrate(input logic ifirst_f, input logic iren,
                                       input logic dren, input logic dwen);
    state_t g;
    g = IDLE;
    if (ifirst_f && iren) g = IRD;
    else if (dwen)        g = DWR;
    else if (dren)        g = DRD;
    else if (iren)        g = IRD;
    return g;
  endfunction

  always_comb begin
    gnt       = arbitrate(ifirst, bus.iREN, bus.dREN, bus.dWEN);
    ram_ok    = (bus.ramstate == RS_ACCESS);
    ram_abort = !ram_ok && ((bus.ramstate == RS_ERROR) || (cnt == CNT_MAX));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      own_d    <= 1'b0;
      ifirst   <= 1'b0;
      memerr_q <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      iwait_q  <= 1'b1;
      dwait_q  <= 1'b1;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      // Strobes and wait pulses are re-asserted explicitly by the state
      // that wants them; everything else drops them.
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt != IDLE) begin
            // Everything the transaction needs is captured here so that
            // request inputs may change or drop while it is in flight.
            state   <= gnt;
            cnt     <= '0;
            addr_q  <= (gnt == IRD) ? bus.iaddr : bus.daddr;
            store_q <= bus.dstore;
            own_d   <= (gnt != IRD);
            ren_q   <= (gnt != DWR);
            wen_q   <= (gnt == DWR);
            if (gnt == IRD) ifirst <= 1'b0;
          end
        end

        IRD, DRD, DWR: begin
          if (ram_ok || ram_abort) begin
            state   <= RESP;
            iwait_q <= own_d;
            dwait_q <= !own_d;
            if (ram_ok) begin
              if (state == IRD) iload_q <= bus.ramload;
              if (state == DRD) dload_q <= bus.ramload;
            end else begin
              memerr_q <= 1'b1;
              if (state == IRD) iload_q <= ERRWORD;
              if (state == DRD) dload_q <= ERRWORD;
            end
            // A fetch that waited through this data access goes next.
            if (own_d && bus.iREN) ifirst <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            ren_q <= (state != DWR);
            wen_q <= (state == DWR);
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.iwait    = iwait_q;
  assign bus.iload    = iload_q;
  assign bus.dwait    = dwait_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.memerr   = memerr_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

- Sits directly downstream of the cache block.
- Takes that block's instruction-fetch and data request/wait handshakes and arbitrates them onto the single RAM port.
- Runs a multi-cycle transaction FSM with registered responses, data-over-instruction priority with an anti-starvation rule, and a per-transaction timeout that reports a sticky error.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles a transaction may wait for RAM ACCESS before it is aborted.
- ERRWORD, 32'hBAD1BAD1: load data returned on an aborted read.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low for exactly one cycle when the instruction response is valid.
- iload  out  32  instruction data, valid while iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly one cycle when the data response completes.
- dload  out  32  read data, valid while dwait is low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate is ACCESS.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky error flag, set on any timeout or ERROR; cleared only by reset.

## Operation
**States:** IDLE, IRD, DRD, DWR, RESP.

**IDLE arbitration** (evaluated each cycle):
- dWEN high → DWR. dWEN high with dREN high counts as a write.
- Else dREN high → DRD.
- Else iREN high → IRD.
- Exception: the ifirst flag is set and iREN is high → IRD, even if a data request is present.
- ifirst is set when a data transaction reaches RESP while iREN is high. It clears when an IRD is granted.

**On grant:**
- Latch address, store data and transaction type into registers.
- Clear the timeout counter.
- Later changes on the request inputs do not affect the transaction in flight.

**IRD / DRD / DWR:**
- Drive ramaddr and ramstore from the latched registers.
- Drive ramREN=1 for reads and ramWEN=1 for writes.
- ramREN and ramWEN are never high together.
- ramstate ACCESS → capture ramload for reads; go to RESP.
- ramstate ERROR, or counter == TIMEOUT → set memerr; response data = ERRWORD for reads; go to RESP.
- Otherwise increment the counter (width $clog2(TIMEOUT+1)).

**RESP:**
- Strobes are low.
- For one cycle, the owning requester's wait is low and its load is driven from the response register.
- Then go to IDLE.
- If the request was withdrawn mid-transaction, the transaction still completes and the response pulse still occurs.

**Outside RESP:** iwait=1, dwait=1, iload and dload hold their last response value.

**Reset** (evaluated when nRST is low at the clock edge):
- State IDLE, ifirst=0, memerr=0, counter=0, latches=0.
- Outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Reset asserted mid-transaction aborts it with no response pulse.

## Timing
**Latency:**
- Request visible in IDLE at cycle 0.
- RAM strobe from cycle 1.
- ACCESS first seen at cycle k (k≥1) → wait low at cycle k+1.
- Minimum 3-cycle turnaround per access, IDLE to IDLE.

**Output timing:**
- All outputs are registered-state decodes. No combinational path from request inputs to wait outputs.
- ramload is sampled only on the ACCESS cycle.

**Timeout:** a read with no ACCESS aborts at cycle TIMEOUT+1 after grant; response at TIMEOUT+2.

**Back-to-back:** requests held high across RESP re-arbitrate in the following IDLE cycle.

## Test plan
- **Zero-latency instruction read:** reset, then iREN=1, iaddr=0x0000_0040, with ACCESS returned on the first strobe cycle and ramload=0x2001_0005 → ramREN high with ramaddr=0x40 at cycle 1; iwait low with iload=0x2001_0005 at cycle 2 only; IDLE at cycle 3.
- **Write priority:** dWEN=1 with daddr=0x100 and dstore=0xDEADBEEF, plus iREN=1, both asserted in the same cycle, with RAM BUSY for 2 cycles then ACCESS → ramWEN with 0x100/0xDEADBEEF first; dwait low once; then IRD granted (ifirst) even though dWEN stays high; iwait pulses after it.
- **Read/write overlap:** dREN=1 and dWEN=1 together → write performed; ramREN stays 0 throughout.
- **Timeout:** ramstate held FREE on a DRD with TIMEOUT=15 → dwait low at cycle 17 after grant with dload=0xBAD1BAD1; memerr=1 and stays 1 through later good transactions until nRST.
- **ERROR and reset abort:** ERROR on the third strobe cycle → memerr set, response next cycle. Separately, nRST low during a BUSY DRD → next cycle all outputs at their reset values and no dwait pulse.
